// File: rtl/res_writeback.sv
// Result write-back stage: 2-entry ping-pong block buffer drained word-by-word to memory port C.
// Optional WB_PERF_CNT_EN adds the wb_word_cnt issued-word counter output.
module res_writeback #(
  parameter int SINGLE_ACCESS = 4,
  parameter int BANDWIDTH     = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 11
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          blk_valid,
  output logic                                          blk_ready,
  input  logic [SINGLE_ACCESS*BANDWIDTH*DATA_WIDTH-1:0] blk_data,
  input  logic [ADDR_WIDTH-1:0]                         blk_addr,
  input  logic                                          blk_last,
  output logic                                          mem_write,
  input  logic                                          mem_ready,
  output logic [ADDR_WIDTH-1:0]                         mem_address,
  output logic [BANDWIDTH*DATA_WIDTH-1:0]               mem_writedata,
  output logic [BANDWIDTH*DATA_WIDTH/8-1:0]             mem_byteenable,
  output logic                                          op_done,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]                                   wb_word_cnt,
`endif
  output logic                                          busy
);
  localparam int WW   = BANDWIDTH * DATA_WIDTH;
  localparam int BLKW = SINGLE_ACCESS * WW;
  localparam int IW   = (SINGLE_ACCESS > 1) ? $clog2(SINGLE_ACCESS) : 1;

  typedef struct packed {
    logic [BLKW-1:0]       data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
  } entry_t;

  typedef enum logic {IDLE, DRAIN} state_t;

  entry_t          ent [2];
  state_t          state, state_nxt;
  logic [1:0]      count, count_nxt;
  logic            wr_sel, rd_sel;
  logic [IW-1:0]   word_idx;
  logic            accept, issue, fin;
  logic [WW-1:0]   cur_words [SINGLE_ACCESS];

  assign accept = blk_valid & blk_ready;
  assign issue  = mem_write & mem_ready;
  assign fin    = issue & (word_idx == IW'(SINGLE_ACCESS - 1));

  // Ready depends on registered occupancy only, never on mem_ready.
  assign blk_ready = (count < 2'd2);

  for (genvar i = 0; i < SINGLE_ACCESS; i++) begin : g_word
    assign cur_words[i] = ent[rd_sel].data[i*WW +: WW];
  end

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    case ({accept, fin})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
    state_nxt      = (count_nxt != 2'd0) ? DRAIN : IDLE;
    mem_write      = (state == DRAIN);
    mem_address    = ent[rd_sel].addr + ADDR_WIDTH'(word_idx);
    mem_writedata  = cur_words[word_idx];
    mem_byteenable = {(WW/8){mem_write}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 2'd0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      word_idx <= '0;
      op_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      op_done <= fin & ent[rd_sel].last;
      if (accept) wr_sel <= ~wr_sel;
      if (issue) begin
        if (fin) begin
          word_idx <= '0;
          rd_sel   <= ~rd_sel;
        end else begin
          word_idx <= word_idx + IW'(1);
        end
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (accept) ent[wr_sel] <= '{data: blk_data, addr: blk_addr, last: blk_last};
  end

  assign busy = (count != 2'd0) | op_done;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)                             wb_word_cnt <= 32'd0;
    else if (fin & ent[rd_sel].last)       wb_word_cnt <= 32'd0;
    else if (issue && wb_word_cnt != '1)   wb_word_cnt <= wb_word_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_res_writeback.sv
// Self-checking bench for res_writeback: constant vector table, directed corner sequences,
// and randomized traffic against a queue-based model of the block buffer.
module tb_res_writeback;
  localparam int SA   = 4;
  localparam int BW   = 8;
  localparam int DW   = 32;
  localparam int AW   = 11;
  localparam int WW   = BW * DW;
  localparam int BLKW = SA * WW;

  logic              clock = 1'b0;
  logic              reset;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLKW-1:0]   blk_data;
  logic [AW-1:0]     blk_addr;
  logic              blk_last;
  logic              mem_write;
  logic              mem_ready;
  logic [AW-1:0]     mem_address;
  logic [WW-1:0]     mem_writedata;
  logic [WW/8-1:0]   mem_byteenable;
  logic              op_done;
  logic              busy;
`ifdef WB_PERF_CNT_EN
  logic [31:0]       wb_word_cnt;
`endif

  res_writeback #(.SINGLE_ACCESS(SA), .BANDWIDTH(BW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_addr(blk_addr), .blk_last(blk_last),
    .mem_write(mem_write), .mem_ready(mem_ready), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .op_done(op_done),
`ifdef WB_PERF_CNT_EN
    .wb_word_cnt(wb_word_cnt),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [BLKW-1:0] data;
    logic [AW-1:0]   addr;
    logic            last;
  } blk_t;

  blk_t        q[$];
  int          widx;
  logic        exp_done;
  logic [31:0] exp_cnt;
  int          cyc, nwr, ndone, first_wr, last_wr;
  bit          saw_not_ready;

  function automatic logic [WW-1:0] word_of(input logic [BLKW-1:0] d, input int w);
    return d[w*WW +: WW];
  endfunction

  task automatic model_clear();
    q.delete();
    widx = 0;
    exp_done = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    blk_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One cycle: drive inputs, check outputs against model mid-cycle, advance model after edge.
  task automatic step(input logic v, input logic [BLKW-1:0] d, input logic [AW-1:0] a,
                      input logic l, input logic r, output logic acc);
    logic iss;
    blk_t nb;
    blk_valid = v; blk_data = d; blk_addr = a; blk_last = l; mem_ready = r;
    @(negedge clock);
    chk("blk_ready", {255'd0, blk_ready}, {255'd0, q.size() < 2});
    chk("mem_write", {255'd0, mem_write}, {255'd0, q.size() != 0});
    chk("op_done",   {255'd0, op_done},   {255'd0, exp_done});
    chk("busy",      {255'd0, busy},      {255'd0, (q.size() != 0) || exp_done});
    if (q.size() != 0) begin
      chk("mem_address",    {245'd0, mem_address}, {245'd0, AW'(q[0].addr + AW'(widx))});
      chk("mem_writedata",  mem_writedata, word_of(q[0].data, widx));
      chk("mem_byteenable", {224'd0, mem_byteenable}, {224'd0, 32'hFFFF_FFFF});
    end else begin
      chk("mem_byteenable", {224'd0, mem_byteenable}, '0);
    end
`ifdef WB_PERF_CNT_EN
    chk("wb_word_cnt", {224'd0, wb_word_cnt}, {224'd0, exp_cnt});
`endif
    if (!blk_ready) saw_not_ready = 1'b1;
    if (op_done) ndone++;
    acc = v && (q.size() < 2);
    iss = (q.size() != 0) && r;
    @(posedge clock); #1;
    cyc++;
    exp_done = 1'b0;
    if (iss) begin
      nwr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      widx++;
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      if (widx == SA) begin
        exp_done = q[0].last;
        if (exp_done) exp_cnt = 32'd0;
        void'(q.pop_front());
        widx = 0;
      end
    end
    if (acc) begin
      nb.data = d; nb.addr = a; nb.last = l;
      q.push_back(nb);
    end
  endtask

  function automatic logic [BLKW-1:0] rand_blk();
    logic [BLKW-1:0] d;
    for (int k = 0; k < BLKW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- constant vector table ----------------
  typedef struct {
    logic        v;
    logic [AW-1:0] a;
    logic        l;
    logic        r;
    logic        e_rdy;
    logic        e_wr;
    logic [AW-1:0] e_addr;
    int          e_widx;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t            tbl [11];
  logic [BLKW-1:0] fixed_blk;
  logic            acc;
  int              idx;
  logic [AW-1:0]   bases [3];

  initial begin
    for (int w = 0; w < SA; w++)
      for (int e = 0; e < BW; e++)
        fixed_blk[(w*BW+e)*DW +: DW] = {16'hD000 + 16'(w), 16'(e)};

    //          v     addr     l     r     rdy   wr    e_addr   widx done  busy
    tbl[0]  = '{1'b1, 11'h040, 1'b1, 1'b1, 1'b1, 1'b0, 11'h000, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h040, 0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h041, 1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h042, 2, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h043, 3, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 11'h7FE, 1'b0, 1'b1, 1'b1, 1'b0, 11'h000, 0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h7FE, 0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h7FF, 1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h000, 2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 11'h001, 3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b0, 11'h000, 0, 1'b0, 1'b0};

    blk_data = '0; blk_addr = '0; blk_last = 1'b0;
    cyc = 0; nwr = 0; ndone = 0; first_wr = -1; last_wr = -1; saw_not_ready = 1'b0;
    @(posedge clock); #1;
    do_reset();

    // Single block then a wrapping non-last block, all expectations are constants.
    for (int i = 0; i < 11; i++) begin
      blk_valid = tbl[i].v; blk_addr = tbl[i].a; blk_last = tbl[i].l;
      mem_ready = tbl[i].r; blk_data = fixed_blk;
      @(negedge clock);
      chk($sformatf("tbl%0d blk_ready", i), {255'd0, blk_ready}, {255'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d mem_write", i), {255'd0, mem_write}, {255'd0, tbl[i].e_wr});
      chk($sformatf("tbl%0d op_done", i),   {255'd0, op_done},   {255'd0, tbl[i].e_done});
      chk($sformatf("tbl%0d busy", i),      {255'd0, busy},      {255'd0, tbl[i].e_busy});
      if (tbl[i].e_wr) begin
        chk($sformatf("tbl%0d mem_address", i), {245'd0, mem_address}, {245'd0, tbl[i].e_addr});
        chk($sformatf("tbl%0d mem_writedata", i), mem_writedata, word_of(fixed_blk, tbl[i].e_widx));
      end
      @(posedge clock); #1;
    end

    // Three blocks offered back-to-back: no bubbles, ready drops while two are held.
    do_reset();
    bases[0] = 11'h000; bases[1] = 11'h004; bases[2] = 11'h008;
    nwr = 0; first_wr = -1; last_wr = -1; saw_not_ready = 1'b0; idx = 0;
    for (int c = 0; c < 20; c++) begin
      step(idx < 3, rand_blk(), (idx < 3) ? bases[idx] : 11'h000, idx == 2, 1'b1, acc);
      if (acc) idx++;
    end
    chk("b2b words", 256'(nwr), 256'd12);
    chk("b2b contiguous", 256'(last_wr - first_wr + 1), 256'd12);
    chk("b2b ready dropped", {255'd0, saw_not_ready}, {255'd0, 1'b1});

    // mem_ready stalls mid-drain.
    do_reset();
    nwr = 0; ndone = 0;
    step(1'b1, rand_blk(), 11'h100, 1'b1, 1'b1, acc);
    begin
      logic pat [10];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b0, pat[c], acc);
    end
    chk("stall words", 256'(nwr), 256'd4);
    chk("stall op_done count", 256'(ndone), 256'd1);

    // Reset after two words of a last block: buffer discarded, no op_done.
    do_reset();
    ndone = 0;
    step(1'b1, rand_blk(), 11'h200, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    do_reset();
    @(negedge clock);
    chk("rst mem_write", {255'd0, mem_write}, '0);
    chk("rst op_done",   {255'd0, op_done},   '0);
    chk("rst blk_ready", {255'd0, blk_ready}, {255'd0, 1'b1});
    chk("rst busy",      {255'd0, busy},      '0);
    @(posedge clock); #1;
    for (int c = 0; c < 6; c++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("rst no op_done", 256'(ndone), 256'd0);

    // Randomized traffic against the model.
    do_reset();
    begin
      logic            pend;
      logic [BLKW-1:0] pd;
      logic [AW-1:0]   pa;
      logic            pl;
      pend = 1'b0; pd = '0; pa = '0; pl = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (!pend && ($urandom_range(0, 2) != 0)) begin
          pend = 1'b1; pd = rand_blk(); pa = AW'($urandom); pl = 1'($urandom);
        end
        step(pend, pd, pa, pl, $urandom_range(0, 3) != 0, acc);
        if (acc) pend = 1'b0;
      end
      for (int c = 0; c < 12; c++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
